keypad_scan: RTL and testbench

- Input-side counterpart of the 4-digit seven-segment scanner: scans a 4x4 matrix keypad row by row, debounces, and reports each new key press to the CPU.
- Sits on the CPU I/O bus. Each press raises key_valid with a 4-bit hex code; the CPU clears it with key_ack.
- Each accepted press is also shifted into a 16-bit value register (4 hex digits). That register can be wired straight to the display scanner's data input.

---
 rtl/keypad_scan.sv | 189 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row-by-row drive, per-pass decode, debounce FSM,
// and a CPU-facing key register with a 4-digit history shift register.
module keypad_scan #(
    parameter int SCAN_DIV = 2000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_out,
    input  logic [3:0]  col_in,
    input  logic        key_ack,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic        key_overrun,
    output logic [15:0] kbd_value
);
    localparam int              DIV_W   = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB     = 4'(DEBOUNCE);

    typedef enum logic [1:0] {S_IDLE, S_PRESS_DEB, S_HELD, S_REL_DEB} state_t;

    logic [3:0]       r_sync1, r_sync2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row;
    logic [3:0]       r_row_out;
    logic             r_acc_any, r_acc_multi;
    logic [3:0]       r_acc_code;
    state_t           r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]       r_cand, w_cand_nxt;
    logic             r_key_valid, r_key_overrun;
    logic [3:0]       r_key_code;
    logic [15:0]      r_kbd_value;

    logic       w_tick, w_pass_end, w_press;
    logic [1:0] w_row_nxt, w_col;
    logic [3:0] w_low;
    logic [2:0] w_nlow;
    logic       w_pass_any, w_pass_multi, w_is_key, w_is_none;
    logic [3:0] w_pass_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= col_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick     = (r_div == DIV_MAX);
    assign w_pass_end = w_tick && (r_row == 2'd3);
    assign w_row_nxt  = r_row + 2'd1;
    assign w_low      = ~r_sync2;
    assign w_nlow     = {2'b0, w_low[0]} + {2'b0, w_low[1]} + {2'b0, w_low[2]} + {2'b0, w_low[3]};

    always_comb begin
        w_col = 2'd0;
        if (w_low[1]) w_col = 2'd1;
        if (w_low[2]) w_col = 2'd2;
        if (w_low[3]) w_col = 2'd3;
    end

    // Result of the pass so far, including the row being sampled this tick.
    assign w_pass_any   = r_acc_any | (w_low != 4'd0);
    assign w_pass_multi = r_acc_multi | (w_nlow >= 3'd2) | (r_acc_any & (w_low != 4'd0));
    assign w_pass_code  = r_acc_any ? r_acc_code : {r_row, w_col};
    assign w_is_key     = w_pass_any & ~w_pass_multi;
    assign w_is_none    = ~w_pass_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_row       <= 2'd0;
            r_row_out   <= 4'b1110;
            r_acc_any   <= 1'b0;
            r_acc_multi <= 1'b0;
            r_acc_code  <= 4'd0;
        end else if (w_tick) begin
            r_div     <= '0;
            r_row     <= w_row_nxt;
            r_row_out <= ~(4'b0001 << w_row_nxt);
            if (w_pass_end) begin
                r_acc_any   <= 1'b0;
                r_acc_multi <= 1'b0;
                r_acc_code  <= 4'd0;
            end else begin
                r_acc_any   <= w_pass_any;
                r_acc_multi <= w_pass_multi;
                r_acc_code  <= w_pass_code;
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    assign w_cnt_inc = r_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_press     = 1'b0;
        if (w_pass_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_key) begin
                        w_cand_nxt = w_pass_code;
                        w_cnt_nxt  = 4'd1;
                        if (DEBOUNCE == 1) begin
                            w_state_nxt = S_HELD;
                            w_press     = 1'b1;
                        end else begin
                            w_state_nxt = S_PRESS_DEB;
                        end
                    end
                end
                S_PRESS_DEB: begin
                    if (w_is_key && (w_pass_code == r_cand)) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == DEB) begin
                            w_state_nxt = S_HELD;
                            w_press     = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_HELD: begin
                    // No auto-repeat: a held key, or a roll to MULTI, stays here.
                    if (w_is_none) begin
                        w_cnt_nxt   = 4'd1;
                        w_state_nxt = (DEBOUNCE == 1) ? S_IDLE : S_REL_DEB;
                    end
                end
                S_REL_DEB: begin
                    if (w_is_none) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == DEB) w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_HELD;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A press beats a same-cycle ack: valid stays set, overrun is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_valid   <= 1'b0;
            r_key_overrun <= 1'b0;
            r_key_code    <= 4'd0;
            r_kbd_value   <= 16'd0;
        end else if (w_press) begin
            r_key_code    <= w_cand_nxt;
            r_kbd_value   <= {r_kbd_value[11:0], w_cand_nxt};
            r_key_valid   <= 1'b1;
            r_key_overrun <= r_key_valid & ~key_ack;
        end else if (key_ack && r_key_valid) begin
            r_key_valid   <= 1'b0;
            r_key_overrun <= 1'b0;
        end
    end

    assign row_out     = r_row_out;
    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_overrun = r_key_overrun;
    assign kbd_value   = r_kbd_value;
    assign key_down    = (r_state == S_HELD) || (r_state == S_REL_DEB);
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural two-key matrix model.
module tb_keypad_scan;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_out;
    logic [3:0]  col_in;
    logic        key_ack;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic        key_overrun;
    logic [15:0] kbd_value;

    logic       ka_on, kb_on;
    logic [1:0] ka_r, ka_c, kb_r, kb_c;
    int n_pass = 0;
    int n_total = 0;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clk(clk), .rst(rst), .row_out(row_out), .col_in(col_in),
        .key_ack(key_ack), .key_valid(key_valid), .key_code(key_code),
        .key_down(key_down), .key_overrun(key_overrun), .kbd_value(kbd_value)
    );

    always #5 clk = ~clk;

    // Pressed switch shorts its column to the active (low) row.
    always_comb begin
        col_in = 4'hF;
        if (ka_on && !row_out[ka_r]) col_in[ka_c] = 1'b0;
        if (kb_on && !row_out[kb_r]) col_in[kb_c] = 1'b0;
    end

    // Returns #1 after the edge where row_out steps 0111 -> 1110 (pass boundary).
    task automatic wait_pass(input int n);
        logic [3:0] prv;
        bit done;
        for (int i = 0; i < n; i++) begin
            done = 1'b0;
            for (int t = 0; t < 40 && !done; t++) begin
                prv = row_out;
                @(posedge clk); #1;
                if (prv == 4'b0111 && row_out == 4'b1110) done = 1'b1;
            end
            if (!done) begin
                n_total++;
                $display("FAIL pass_timeout row_out=%b, required a 0111->1110 step", row_out);
            end
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        ka_r = r; ka_c = c; ka_on = 1'b1;
    endtask

    task automatic pulse_ack();
        key_ack = 1'b1;
        @(posedge clk); #1;
        key_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] exp_row;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (row_out !== 4'b1110) $display("FAIL rst_row_out got %b want 1110", row_out); else n_pass++;
        n_total++; if (key_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", key_valid); else n_pass++;
        n_total++; if (kbd_value !== 16'h0) $display("FAIL rst_kbd got %h want 0000", kbd_value); else n_pass++;
        n_total++; if ({key_down, key_overrun, key_code} !== 6'd0) $display("FAIL rst_misc got %b want 000000", {key_down, key_overrun, key_code}); else n_pass++;
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            exp_row = 2'((k / 4) % 4);
            n_total++;
            if (row_out !== ~(4'b0001 << exp_row)) $display("FAIL idle_row k=%0d got %b want %b", k, row_out, ~(4'b0001 << exp_row));
            else n_pass++;
        end
        n_total++; if ({key_valid, key_down, kbd_value} !== 18'd0) $display("FAIL idle_quiet got %h want 0", {key_valid, key_down, kbd_value}); else n_pass++;
    endtask

    task automatic test_press();
        wait_pass(1);
        press(2'd2, 2'd1);
        wait_pass(1);
        n_total++; if (key_valid !== 1'b0) $display("FAIL press_early got valid=%b want 0", key_valid); else n_pass++;
        wait_pass(1);
        n_total++; if (key_valid !== 1'b1 || key_code !== 4'h9) $display("FAIL press_event got v=%b code=%h want v=1 code=9", key_valid, key_code); else n_pass++;
        n_total++; if (kbd_value !== 16'h0009 || key_down !== 1'b1) $display("FAIL press_kbd got kbd=%h down=%b want 0009/1", kbd_value, key_down); else n_pass++;
        wait_pass(3);
        n_total++; if (kbd_value !== 16'h0009 || key_overrun !== 1'b0) $display("FAIL press_norepeat got kbd=%h ovr=%b want 0009/0", kbd_value, key_overrun); else n_pass++;
        ka_on = 1'b0;
        wait_pass(1);
        n_total++; if (key_down !== 1'b1) $display("FAIL release_deb got down=%b want 1", key_down); else n_pass++;
        wait_pass(1);
        n_total++; if (key_down !== 1'b0 || key_valid !== 1'b1) $display("FAIL release_done got down=%b v=%b want 0/1", key_down, key_valid); else n_pass++;
    endtask

    task automatic test_glitch();
        pulse_ack();
        n_total++; if (key_valid !== 1'b0) $display("FAIL ack_clear got v=%b want 0", key_valid); else n_pass++;
        wait_pass(1);
        press(2'd1, 2'd0);
        wait_pass(1);
        ka_on = 1'b0;
        wait_pass(3);
        n_total++; if (key_valid !== 1'b0 || key_down !== 1'b0 || kbd_value !== 16'h0009) $display("FAIL glitch got v=%b down=%b kbd=%h want 0/0/0009", key_valid, key_down, kbd_value); else n_pass++;
        press(2'd1, 2'd0);
        wait_pass(2);
        n_total++; if (key_valid !== 1'b1 || kbd_value !== 16'h0094) $display("FAIL glitch_press got v=%b kbd=%h want 1/0094", key_valid, kbd_value); else n_pass++;
        ka_on = 1'b0;
        pulse_ack();
        wait_pass(1);
        ka_on = 1'b1;
        wait_pass(2);
        n_total++; if (key_down !== 1'b1 || key_valid !== 1'b0 || kbd_value !== 16'h0094) $display("FAIL bounce got down=%b v=%b kbd=%h want 1/0/0094", key_down, key_valid, kbd_value); else n_pass++;
        ka_on = 1'b0;
        wait_pass(2);
        n_total++; if (key_down !== 1'b0) $display("FAIL bounce_release got down=%b want 0", key_down); else n_pass++;
    endtask

    task automatic test_sequence();
        logic [3:0] codes [5];
        codes = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        for (int i = 0; i < 5; i++) begin
            press(codes[i][3:2], codes[i][1:0]);
            wait_pass(2);
            n_total++; if (key_valid !== 1'b1 || key_code !== codes[i]) $display("FAIL seq_code i=%0d got v=%b code=%h want 1/%h", i, key_valid, key_code, codes[i]); else n_pass++;
            n_total++; if (key_overrun !== 1'b0) $display("FAIL seq_overrun i=%0d got %b want 0", i, key_overrun); else n_pass++;
            ka_on = 1'b0;
            pulse_ack();
            wait_pass(2);
        end
        n_total++; if (kbd_value !== 16'h2345) $display("FAIL seq_kbd got %h want 2345", kbd_value); else n_pass++;
    endtask

    task automatic test_overrun();
        press(2'd2, 2'd2);
        wait_pass(2);
        ka_on = 1'b0;
        wait_pass(2);
        press(2'd3, 2'd3);
        wait_pass(2);
        n_total++; if (key_overrun !== 1'b1 || key_valid !== 1'b1 || key_code !== 4'hF) $display("FAIL ovr_set got ovr=%b v=%b code=%h want 1/1/F", key_overrun, key_valid, key_code); else n_pass++;
        n_total++; if (kbd_value !== 16'h45AF) $display("FAIL ovr_kbd got %h want 45AF", kbd_value); else n_pass++;
        ka_on = 1'b0;
        wait_pass(2);
        pulse_ack();
        n_total++; if (key_valid !== 1'b0 || key_overrun !== 1'b0) $display("FAIL ovr_ack got v=%b ovr=%b want 0/0", key_valid, key_overrun); else n_pass++;
        press(2'd1, 2'd3);
        wait_pass(2);
        ka_on = 1'b0;
        wait_pass(2);
        press(2'd0, 2'd0);
        wait_pass(1);
        repeat (15) @(posedge clk);
        #1 key_ack = 1'b1;
        @(posedge clk); #1;
        key_ack = 1'b0;
        n_total++; if (key_valid !== 1'b1 || key_overrun !== 1'b0) $display("FAIL same_cycle got v=%b ovr=%b want 1/0", key_valid, key_overrun); else n_pass++;
        n_total++; if (key_code !== 4'h0 || kbd_value !== 16'hAF70) $display("FAIL same_cycle_code got code=%h kbd=%h want 0/AF70", key_code, kbd_value); else n_pass++;
        ka_on = 1'b0;
        wait_pass(2);
        pulse_ack();
    endtask

    task automatic test_multi();
        wait_pass(1);
        press(2'd1, 2'd0);
        kb_r = 2'd1; kb_c = 2'd2; kb_on = 1'b1;
        wait_pass(4);
        n_total++; if (key_valid !== 1'b0 || key_down !== 1'b0 || kbd_value !== 16'hAF70) $display("FAIL multi_row got v=%b down=%b kbd=%h want 0/0/AF70", key_valid, key_down, kbd_value); else n_pass++;
        press(2'd0, 2'd1);
        kb_r = 2'd3; kb_c = 2'd2;
        wait_pass(4);
        n_total++; if (key_valid !== 1'b0 || key_down !== 1'b0 || kbd_value !== 16'hAF70) $display("FAIL multi_rows got v=%b down=%b kbd=%h want 0/0/AF70", key_valid, key_down, kbd_value); else n_pass++;
        ka_on = 1'b0; kb_on = 1'b0;
    endtask

    task automatic test_reset_mid();
        wait_pass(1);
        press(2'd2, 2'd1);
        wait_pass(1);
        repeat (6) @(posedge clk);
        #1 ka_on = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if (row_out !== 4'b1110 || kbd_value !== 16'h0) $display("FAIL mid_rst got row=%b kbd=%h want 1110/0000", row_out, kbd_value); else n_pass++;
        n_total++; if ({key_valid, key_down, key_overrun, key_code} !== 7'd0) $display("FAIL mid_rst_flags got %b want 0", {key_valid, key_down, key_overrun, key_code}); else n_pass++;
        rst = 1'b0;
        wait_pass(3);
        n_total++; if (key_valid !== 1'b0 || kbd_value !== 16'h0) $display("FAIL post_rst got v=%b kbd=%h want 0/0000", key_valid, kbd_value); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; key_ack = 1'b0;
        ka_on = 1'b0; kb_on = 1'b0;
        ka_r = 2'd0; ka_c = 2'd0; kb_r = 2'd0; kb_c = 2'd0;
        test_reset();
        test_press();
        test_glitch();
        test_sequence();
        test_overrun();
        test_multi();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
